// File: rtl/fpu_ftoi_pipe_pkg.sv
// Shared FPU definitions: rounding-mode encodings and the bit positions
// of the exception flags carried alongside a conversion result.
package fpu_ftoi_pipe_pkg;

  localparam logic [1:0] C_RM_NEAREST  = 2'd0;
  localparam logic [1:0] C_RM_TRUNC    = 2'd1;
  localparam logic [1:0] C_RM_PLUSINF  = 2'd2;
  localparam logic [1:0] C_RM_MINUSINF = 2'd3;

  localparam int C_FLAG_ZERO = 0;
  localparam int C_FLAG_IV   = 1;
  localparam int C_FLAG_IX   = 2;
  localparam int C_FLAG_OF   = 3;
  localparam int C_NUM_FLAGS = 4;

  typedef logic [C_NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/fpu_ftoi_pipe_round.sv
// Rounding, range saturation and flag generation for float-to-int.
// Takes the aligned integer magnitude (one spare bit above the result
// width), the guard and sticky bits and the special-case markers.
module fpu_ftoi_round
  import fpu_ftoi_pipe_pkg::*;
#(
  parameter int C_INT = 32
) (
  input  logic [C_INT:0]   i_mag,
  input  logic             i_guard,
  input  logic             i_sticky,
  input  logic             i_sign,
  input  logic [1:0]       i_rm,
  input  logic             i_unsigned,
  input  logic             i_nan,
  input  logic             i_inf,
  input  logic             i_oor,
  output logic [C_INT-1:0] o_result,
  output flags_t           o_flags
);

  // Largest magnitudes representable in each mode, one carry bit wider
  // than the rounded magnitude so comparisons need no extra extension.
  localparam logic [C_INT+1:0] C_SMAG_POS = {3'b000, {(C_INT-1){1'b1}}};
  localparam logic [C_INT+1:0] C_SMAG_NEG = {3'b001, {(C_INT-1){1'b0}}};
  localparam logic [C_INT+1:0] C_UMAG     = {2'b00, {C_INT{1'b1}}};
  localparam logic [C_INT-1:0] C_SMAX     = {1'b0, {(C_INT-1){1'b1}}};
  localparam logic [C_INT-1:0] C_SMIN     = {1'b1, {(C_INT-1){1'b0}}};
  localparam logic [C_INT-1:0] C_UMAX     = {C_INT{1'b1}};

  logic             w_inexact;
  logic             w_inc;
  logic             w_ovf;
  logic             w_of;
  logic             w_iv;
  logic [C_INT+1:0] w_rounded;
  logic [C_INT-1:0] w_result;

  // Round the magnitude, then let NaN, unsigned negatives and out-of-range values override it.
  always_comb begin
    w_inexact = i_guard | i_sticky;
    w_inc     = 1'b0;
    case (i_rm)
      C_RM_NEAREST:  w_inc = i_guard & (i_sticky | i_mag[0]);
      C_RM_TRUNC:    w_inc = 1'b0;
      C_RM_PLUSINF:  w_inc = ~i_sign & w_inexact;
      C_RM_MINUSINF: w_inc = i_sign & w_inexact;
      default:       w_inc = 1'b0;
    endcase
    w_rounded = {1'b0, i_mag} + {{(C_INT+1){1'b0}}, w_inc};

    if (i_unsigned)  w_ovf = w_rounded > C_UMAG;
    else if (i_sign) w_ovf = w_rounded > C_SMAG_NEG;
    else             w_ovf = w_rounded > C_SMAG_POS;

    w_result = i_sign ? -w_rounded[C_INT-1:0] : w_rounded[C_INT-1:0];
    w_of     = 1'b0;
    w_iv     = 1'b0;
    if (i_nan) begin
      w_result = i_unsigned ? C_UMAX : C_SMAX;
      w_iv     = 1'b1;
    end else if (i_unsigned && i_sign && !i_inf) begin
      w_result = '0;
      w_iv     = i_oor | (w_rounded != '0);
    end else if (i_inf || i_oor || w_ovf) begin
      w_of     = 1'b1;
      w_iv     = 1'b1;
      if (i_sign) w_result = i_unsigned ? '0 : C_SMIN;
      else        w_result = i_unsigned ? C_UMAX : C_SMAX;
    end

    o_result             = w_result;
    o_flags              = '0;
    o_flags[C_FLAG_OF]   = w_of;
    o_flags[C_FLAG_IV]   = w_iv;
    o_flags[C_FLAG_IX]   = w_inexact & ~w_iv;
    o_flags[C_FLAG_ZERO] = (w_result == '0) & ~w_iv;
  end

endmodule

// File: rtl/fpu_ftoi_pipe.sv
// Two-stage float-to-integer converter with valid/ready handshaking.
// Stage 1 unpacks the operand and aligns the mantissa to the integer
// point; stage 2 rounds, saturates and registers result plus flags.
module fpu_ftoi_pipe
  import fpu_ftoi_pipe_pkg::*;
#(
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23,
  parameter int C_BIAS = 127,
  parameter int C_INT  = 32
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_SI,
  input  logic                    InValid_SI,
  output logic                    InReady_SO,
  input  logic [C_EXP+C_MANT:0]   Operand_DI,
  input  logic [1:0]              RM_SI,
  input  logic                    Unsigned_SI,
  output logic                    OutValid_SO,
  input  logic                    OutReady_SI,
  output logic [C_INT-1:0]        Result_DO,
  output logic                    OF_SO,
  output logic                    IX_SO,
  output logic                    IV_SO,
  output logic                    Zero_SO
);

  // Shifter holds the integer part (one spare bit for overflow detection),
  // the guard position and the remaining fraction bits.
  localparam int C_SW  = C_MANT + C_INT + 2;
  localparam int C_SHW = C_EXP + 2;

  logic                    w_sign;
  logic [C_EXP-1:0]        w_exp;
  logic [C_MANT-1:0]       w_frac;
  logic                    w_nan;
  logic                    w_inf;
  logic                    w_oor;
  logic signed [C_SHW-1:0] w_shift;
  logic [C_SHW-1:0]        w_lAmt;
  logic [C_SHW-1:0]        w_rAmt;
  logic [C_SW-1:0]         w_base;
  logic [C_SW-1:0]         w_left;
  logic [C_SW-1:0]         w_aligned;
  logic                    w_lost;
  logic                    w_adv1;
  logic                    w_adv2;
  logic                    w_accept;
  logic [C_INT-1:0]        w_rndResult;
  flags_t                  w_rndFlags;

  logic             r_s1Valid;
  logic [C_INT:0]   r_s1Mag;
  logic             r_s1Guard;
  logic             r_s1Sticky;
  logic             r_s1Sign;
  logic [1:0]       r_s1Rm;
  logic             r_s1Uns;
  logic             r_s1Nan;
  logic             r_s1Inf;
  logic             r_s1Oor;
  logic             r_s2Valid;
  logic [C_INT-1:0] r_s2Result;
  flags_t           r_s2Flags;

  assign w_sign = Operand_DI[C_EXP+C_MANT];
  assign w_exp  = Operand_DI[C_EXP+C_MANT-1:C_MANT];
  assign w_frac = Operand_DI[C_MANT-1:0];

  // A stage moves when it is empty or its successor moves this cycle.
  assign w_adv2     = ~r_s2Valid | OutReady_SI;
  assign w_adv1     = ~r_s1Valid | w_adv2;
  assign InReady_SO = w_adv1 & ~Rst_SI;
  assign w_accept   = InValid_SI & InReady_SO;

  // Unpack and align: left shift for integer exponents, right shift with lost-bit tracking otherwise.
  always_comb begin
    w_nan   = (&w_exp) & (|w_frac);
    w_inf   = (&w_exp) & ~(|w_frac);
    w_shift = $signed({2'b00, w_exp}) - $signed(C_SHW'(C_BIAS));
    w_oor   = w_shift > $signed(C_SHW'(C_INT));
    w_lAmt  = '0;
    w_rAmt  = '0;
    if (!w_shift[C_SHW-1]) begin
      w_lAmt = w_oor ? C_SHW'(C_INT) : $unsigned(w_shift);
    end else begin
      w_rAmt = $unsigned(-w_shift);
      if (w_rAmt > C_SHW'(C_MANT + 3)) w_rAmt = C_SHW'(C_MANT + 3);
    end
    w_base    = C_SW'({|w_exp, w_frac, 1'b0});
    w_left    = w_base << w_lAmt;
    w_aligned = w_left >> w_rAmt;
    w_lost    = (w_aligned << w_rAmt) != w_left;
  end

  // Stage 1 register: capture the aligned operand together with its mode bits.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      r_s1Valid  <= 1'b0;
      r_s1Mag    <= '0;
      r_s1Guard  <= 1'b0;
      r_s1Sticky <= 1'b0;
      r_s1Sign   <= 1'b0;
      r_s1Rm     <= '0;
      r_s1Uns    <= 1'b0;
      r_s1Nan    <= 1'b0;
      r_s1Inf    <= 1'b0;
      r_s1Oor    <= 1'b0;
    end else if (w_adv1) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Mag    <= w_aligned[C_SW-1:C_MANT+1];
        r_s1Guard  <= w_aligned[C_MANT];
        r_s1Sticky <= (|w_aligned[C_MANT-1:0]) | w_lost;
        r_s1Sign   <= w_sign;
        r_s1Rm     <= RM_SI;
        r_s1Uns    <= Unsigned_SI;
        r_s1Nan    <= w_nan;
        r_s1Inf    <= w_inf;
        r_s1Oor    <= w_oor;
      end
    end
  end

  fpu_ftoi_round #(
    .C_INT (C_INT)
  ) u_round (
    .i_mag      (r_s1Mag),
    .i_guard    (r_s1Guard),
    .i_sticky   (r_s1Sticky),
    .i_sign     (r_s1Sign),
    .i_rm       (r_s1Rm),
    .i_unsigned (r_s1Uns),
    .i_nan      (r_s1Nan),
    .i_inf      (r_s1Inf),
    .i_oor      (r_s1Oor),
    .o_result   (w_rndResult),
    .o_flags    (w_rndFlags)
  );

  // Stage 2 register: holds result and flags steady while the consumer stalls.
  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Flags  <= '0;
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Result <= w_rndResult;
        r_s2Flags  <= w_rndFlags;
      end
    end
  end

  assign OutValid_SO = r_s2Valid;
  assign Result_DO   = r_s2Result;
  assign OF_SO       = r_s2Flags[C_FLAG_OF];
  assign IX_SO       = r_s2Flags[C_FLAG_IX];
  assign IV_SO       = r_s2Flags[C_FLAG_IV];
  assign Zero_SO     = r_s2Flags[C_FLAG_ZERO];

endmodule

// File: tb/tb_fpu_ftoi_pipe.sv
// Bench for the float-to-int pipeline: directed corner cases, backpressure,
// mid-flight reset and randomized operands against an arithmetic model.
module tb_fpu_ftoi_pipe;

  localparam logic [3:0] F_OF = 4'b1000;
  localparam logic [3:0] F_IX = 4'b0100;
  localparam logic [3:0] F_IV = 4'b0010;
  localparam logic [3:0] F_ZR = 4'b0001;
  localparam logic [3:0] F_NO = 4'b0000;

  typedef struct {
    logic [31:0] op;
    logic [1:0]  rm;
    logic        uns;
    logic [35:0] expv;
  } item_t;

  logic        Clk_CI = 1'b0;
  logic        Rst_SI = 1'b1;
  logic        InValid_SI = 1'b0;
  logic        InReady_SO;
  logic [31:0] Operand_DI = '0;
  logic [1:0]  RM_SI = '0;
  logic        Unsigned_SI = 1'b0;
  logic        OutValid_SO;
  logic        OutReady_SI = 1'b0;
  logic [31:0] Result_DO;
  logic        OF_SO, IX_SO, IV_SO, Zero_SO;

  item_t expQ[$];
  item_t dirQ[$];
  item_t idleIt;
  int    total = 0;
  int    bad = 0;
  int    readyPct = 100;
  logic  sampledOV;
  logic  sampledRdy;
  logic  acc;

  fpu_ftoi_pipe #(
    .C_EXP (8), .C_MANT (23), .C_BIAS (127), .C_INT (32)
  ) dut (
    .Clk_CI      (Clk_CI),
    .Rst_SI      (Rst_SI),
    .InValid_SI  (InValid_SI),
    .InReady_SO  (InReady_SO),
    .Operand_DI  (Operand_DI),
    .RM_SI       (RM_SI),
    .Unsigned_SI (Unsigned_SI),
    .OutValid_SO (OutValid_SO),
    .OutReady_SI (OutReady_SI),
    .Result_DO   (Result_DO),
    .OF_SO       (OF_SO),
    .IX_SO       (IX_SO),
    .IV_SO       (IV_SO),
    .Zero_SO     (Zero_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact value m*2^k, rounded by comparing the remainder with one half.
  function automatic logic [35:0] refModel(input logic [31:0] op, input logic [1:0] rm, input logic uns);
    logic        sign, of, iv, ix, zero, inexact, up, huge;
    logic [31:0] res;
    int          e, k, n;
    longint      m, q, rem, half, r;
    sign = op[31];
    e    = int'(op[30:23]);
    m    = longint'({e != 0, op[22:0]});
    of = 1'b0; iv = 1'b0; inexact = 1'b0; up = 1'b0; huge = 1'b0; res = '0; r = 0;
    if (e == 255) begin
      iv = 1'b1;
      if (op[22:0] != 0) res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else begin
        of = 1'b1;
        if (sign) res = uns ? 32'h0 : 32'h8000_0000;
        else      res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      end
      return {res, of, 1'b0, iv, 1'b0};
    end
    k = e - 150;
    if (k >= 0) begin
      huge = (k > 30);
      r    = huge ? 0 : (m << k);
    end else begin
      n = -k;
      if (n >= 40) begin
        q = 0; rem = m; half = longint'(1) << 39;
      end else begin
        q = m >> n; rem = m - (q << n); half = longint'(1) << (n - 1);
      end
      inexact = (rem != 0);
      case (rm)
        2'd0: up = (rem > half) || ((rem == half) && q[0]);
        2'd1: up = 1'b0;
        2'd2: up = !sign && inexact;
        default: up = sign && inexact;
      endcase
      r = q + longint'(up);
    end
    if (uns && sign) begin
      res = '0;
      iv  = huge || (r != 0);
    end else if (huge || (uns && r > 64'hFFFF_FFFF) ||
                 (!uns && !sign && r > 64'h7FFF_FFFF) ||
                 (!uns && sign && r > 64'h8000_0000)) begin
      of = 1'b1; iv = 1'b1;
      if (sign) res = 32'h8000_0000;
      else      res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else begin
      res = sign ? 32'(-r) : 32'(r);
    end
    ix   = inexact && !iv;
    zero = (res == 0) && !iv;
    return {res, of, ix, iv, zero};
  endfunction

  function automatic item_t mkItem(input logic [31:0] op, input logic [1:0] rm,
                                   input logic uns, input logic [35:0] expv);
    item_t it;
    it.op = op; it.rm = rm; it.uns = uns; it.expv = expv;
    return it;
  endfunction

  function automatic item_t randItem();
    logic [31:0] op;
    int          cls, e, s;
    logic [1:0]  rm;
    logic        uns;
    op  = $urandom;
    cls = int'($urandom_range(9));
    case (cls)
      0: ;
      1: begin
        op[30:23] = 8'hFF;
        if ($urandom_range(1) == 1) op[22:0] = '0;
      end
      2: op[30:23] = 8'h00;
      3: begin
        e = int'($urandom_range(149, 127));
        s = e - 127;
        op[30:23] = 8'(e);
        op[22:0]  = op[22:0] & ~((23'd1 << (22 - s)) - 23'd1);
        op[22 - s] = 1'b1;
      end
      default: op[30:23] = 8'($urandom_range(162, 110));
    endcase
    rm  = 2'($urandom_range(3));
    uns = 1'($urandom_range(1));
    return mkItem(op, rm, uns, refModel(op, rm, uns));
  endfunction

  // One clock cycle: drive at the falling edge, sample shortly after, track transfers.
  task automatic applyStimulus(input logic vld, input item_t it, output logic accepted);
    string tag;
    @(negedge Clk_CI);
    InValid_SI  = vld;
    Operand_DI  = it.op;
    RM_SI       = it.rm;
    Unsigned_SI = it.uns;
    OutReady_SI = (int'($urandom_range(99)) < readyPct);
    #1;
    sampledOV  = OutValid_SO;
    sampledRdy = InReady_SO;
    accepted   = vld && InReady_SO;
    if (OutValid_SO) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious result", 64'(OutValid_SO), 64'd0);
      end else begin
        tag = $sformatf("%s op=%h rm=%0d u=%0b", OutReady_SI ? "result" : "stalled",
                        expQ[0].op, expQ[0].rm, expQ[0].uns);
        checkOutput(tag, 64'({Result_DO, OF_SO, IX_SO, IV_SO, Zero_SO}), 64'(expQ[0].expv));
        if (OutReady_SI) expQ.delete(0);
      end
    end
    if (accepted) expQ.push_back(it);
  endtask

  task automatic sendOp(input item_t it);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 100 && !a; i++) applyStimulus(1'b1, it, a);
    if (!a) checkOutput("accept timeout", 64'(a), 64'd1);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 300 && expQ.size() != 0; i++) applyStimulus(1'b0, idleIt, a);
    checkOutput("drain pending", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    idleIt = mkItem(32'h0, 2'd0, 1'b0, 36'h0);

    // Reset state.
    repeat (3) @(posedge Clk_CI);
    @(negedge Clk_CI);
    #1;
    checkOutput("reset InReady", 64'(InReady_SO), 64'd0);
    checkOutput("reset OutValid", 64'(OutValid_SO), 64'd0);
    checkOutput("reset result+flags", 64'({Result_DO, OF_SO, IX_SO, IV_SO, Zero_SO}), 64'd0);
    Rst_SI = 1'b0;
    #1;
    checkOutput("InReady after release", 64'(InReady_SO), 64'd1);

    // Latency with no backpressure.
    readyPct = 100;
    applyStimulus(1'b1, mkItem(32'h4020_0000, 2'd0, 1'b0, {32'd2, F_IX}), acc);
    checkOutput("latency accept", 64'(acc), 64'd1);
    applyStimulus(1'b0, idleIt, acc);
    checkOutput("latency cycle1 valid", 64'(sampledOV), 64'd0);
    applyStimulus(1'b0, idleIt, acc);
    checkOutput("latency cycle2 valid", 64'(sampledOV), 64'd1);

    // Directed corner cases with hand-derived expectations.
    dirQ.push_back(mkItem(32'h4020_0000, 2'd1, 1'b0, {32'd2, F_IX}));
    dirQ.push_back(mkItem(32'h4020_0000, 2'd3, 1'b0, {32'd2, F_IX}));
    dirQ.push_back(mkItem(32'h4020_0000, 2'd2, 1'b0, {32'd3, F_IX}));
    dirQ.push_back(mkItem(32'h4060_0000, 2'd0, 1'b0, {32'd4, F_IX}));
    dirQ.push_back(mkItem(32'hC020_0000, 2'd0, 1'b0, {32'hFFFF_FFFE, F_IX}));
    dirQ.push_back(mkItem(32'h3F80_0000, 2'd0, 1'b0, {32'd1, F_NO}));
    dirQ.push_back(mkItem(32'h0000_0000, 2'd0, 1'b0, {32'd0, F_ZR}));
    dirQ.push_back(mkItem(32'h8000_0000, 2'd0, 1'b0, {32'd0, F_ZR}));
    dirQ.push_back(mkItem(32'h8000_0000, 2'd0, 1'b1, {32'd0, F_ZR}));
    dirQ.push_back(mkItem(32'hCF00_0000, 2'd0, 1'b0, {32'h8000_0000, F_NO}));
    dirQ.push_back(mkItem(32'h4F00_0000, 2'd0, 1'b0, {32'h7FFF_FFFF, F_OF | F_IV}));
    dirQ.push_back(mkItem(32'h7FC0_0000, 2'd0, 1'b0, {32'h7FFF_FFFF, F_IV}));
    dirQ.push_back(mkItem(32'hFF80_0000, 2'd0, 1'b0, {32'h8000_0000, F_OF | F_IV}));
    dirQ.push_back(mkItem(32'hBF80_0000, 2'd0, 1'b1, {32'd0, F_IV}));
    dirQ.push_back(mkItem(32'hBE99_999A, 2'd1, 1'b1, {32'd0, F_IX | F_ZR}));
    dirQ.push_back(mkItem(32'h4F7F_FFFF, 2'd0, 1'b1, {32'hFFFF_FF00, F_NO}));
    dirQ.push_back(mkItem(32'h4F80_0000, 2'd0, 1'b1, {32'hFFFF_FFFF, F_OF | F_IV}));
    foreach (dirQ[i]) sendOp(dirQ[i]);
    drain();

    // Backpressure: consumer stalls while four operands are offered back to back.
    readyPct = 0;
    applyStimulus(1'b1, mkItem(32'h3F80_0000, 2'd0, 1'b0, {32'd1, F_NO}), acc);
    checkOutput("bp accept op0", 64'(acc), 64'd1);
    applyStimulus(1'b1, mkItem(32'h4000_0000, 2'd0, 1'b0, {32'd2, F_NO}), acc);
    checkOutput("bp accept op1", 64'(acc), 64'd1);
    applyStimulus(1'b1, mkItem(32'h4040_0000, 2'd0, 1'b0, {32'd3, F_NO}), acc);
    checkOutput("bp InReady low when full", 64'(sampledRdy), 64'd0);
    applyStimulus(1'b1, mkItem(32'h4040_0000, 2'd0, 1'b0, {32'd3, F_NO}), acc);
    checkOutput("bp still blocked", 64'(acc), 64'd0);
    readyPct = 100;
    sendOp(mkItem(32'h4040_0000, 2'd0, 1'b0, {32'd3, F_NO}));
    sendOp(mkItem(32'h4080_0000, 2'd0, 1'b0, {32'd4, F_NO}));
    drain();

    // Reset pulse with two operands in flight: both must vanish.
    applyStimulus(1'b1, mkItem(32'h40A0_0000, 2'd0, 1'b0, {32'd5, F_NO}), acc);
    applyStimulus(1'b1, mkItem(32'h40C0_0000, 2'd0, 1'b0, {32'd6, F_NO}), acc);
    @(negedge Clk_CI);
    Rst_SI      = 1'b1;
    InValid_SI  = 1'b0;
    OutReady_SI = 1'b0;
    @(posedge Clk_CI);
    #1;
    Rst_SI = 1'b0;
    expQ.delete();
    applyStimulus(1'b1, mkItem(32'h40E0_0000, 2'd0, 1'b0, {32'd7, F_NO}), acc);
    checkOutput("post-reset OutValid", 64'(sampledOV), 64'd0);
    checkOutput("post-reset accept", 64'(acc), 64'd1);
    drain();
    repeat (4) applyStimulus(1'b0, idleIt, acc);

    // Randomized operands under varying consumer readiness.
    for (int p = 0; p < 3; p++) begin
      readyPct = (p == 0) ? 100 : ((p == 1) ? 60 : 30);
      $display("[TB] random phase %0d, ready %0d%%", p, readyPct);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(3) == 0) applyStimulus(1'b0, idleIt, acc);
        sendOp(randItem());
      end
      drain();
    end
    readyPct = 100;
    repeat (4) applyStimulus(1'b0, idleIt, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
